// File: rtl/alu_16bit_pkg.sv
// Shared encodings and geometry for the 16-bit ALU with attached data memory.
package alu_16bit_pkg;

  // Operation class supplied by the control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RFMT  = 2'b10;
  localparam logic [1:0] ALUOP_IFMT  = 2'b11;

  // ALUCtrl codes: {Ainvert, Bnegate, op[1:0]}
  localparam logic [3:0] CTRL_AND    = 4'b0000;
  localparam logic [3:0] CTRL_OR     = 4'b0001;
  localparam logic [3:0] CTRL_ADD    = 4'b0010;
  localparam logic [3:0] CTRL_SUB    = 4'b0110;
  localparam logic [3:0] CTRL_SLT    = 4'b0111;
  localparam logic [3:0] CTRL_NOR    = 4'b1100;

  // Datapath and data memory geometry
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MEM_DEPTH  = 128;
  localparam int unsigned MEM_AW     = 7;

endpackage

// File: rtl/alu_16bit_alu_control.sv
// Decodes ALUOp / Funct / Opcode into the 4-bit ALU control word.
module alu_control
  import alu_16bit_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [3:0] Funct,
  input  logic [1:0] Opcode,
  output logic [3:0] ALUCtrl
);

  // Combinational decode; unknown function codes fall back to add
  always_comb begin
    ALUCtrl = CTRL_ADD;
    unique case (ALUOp)
      ALUOP_ADD: ALUCtrl = CTRL_ADD;
      ALUOP_SUB: ALUCtrl = CTRL_SUB;
      ALUOP_RFMT: begin
        case (Funct)
          4'b0000: ALUCtrl = CTRL_AND;
          4'b0001: ALUCtrl = CTRL_OR;
          4'b0010: ALUCtrl = CTRL_ADD;
          4'b0011: ALUCtrl = CTRL_SUB;
          4'b0100: ALUCtrl = CTRL_SLT;
          4'b0101: ALUCtrl = CTRL_NOR;
          default: ALUCtrl = CTRL_ADD;
        endcase
      end
      ALUOP_IFMT: begin
        case (Opcode)
          2'b00:   ALUCtrl = CTRL_ADD;
          2'b01:   ALUCtrl = CTRL_SUB;
          2'b10:   ALUCtrl = CTRL_AND;
          default: ALUCtrl = CTRL_OR;
        endcase
      end
      default: ALUCtrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_16bit.sv
// 16-bit ALU (and/or/add/sub/slt/nor) with a 128x16 byte-addressed data memory.
module alu_16bit
  import alu_16bit_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [1:0]          ALUOp,
  input  logic [3:0]          Funct,
  input  logic [1:0]          Opcode,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [DATA_W-1:0]   WriteData,
  output logic [3:0]          ALUCtrl,
  output logic [DATA_W-1:0]   Result,
  output logic                Zero,
  output logic                Overflow,
  output logic                CarryOut,
  output logic [DATA_W-1:0]   ReadData
);

  logic                a_invert;
  logic                b_negate;
  logic [1:0]          op_sel;
  logic [DATA_W-1:0]   a_eff;
  logic [DATA_W-1:0]   b_eff;
  logic [DATA_W:0]     sum_full;
  logic [DATA_W-1:0]   sum;
  logic                carry_in_msb;
  logic [MEM_AW-1:0]   mem_idx;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  alu_control u_alu_control (
    .ALUOp   (ALUOp),
    .Funct   (Funct),
    .Opcode  (Opcode),
    .ALUCtrl (ALUCtrl)
  );

  assign a_invert = ALUCtrl[3];
  assign b_negate = ALUCtrl[2];
  assign op_sel   = ALUCtrl[1:0];

  // Operand conditioning and adder; Bnegate doubles as carry-in for subtraction
  always_comb begin
    a_eff        = a_invert ? ~A : A;
    b_eff        = b_negate ? ~B : B;
    sum_full     = (DATA_W+1)'(a_eff) + (DATA_W+1)'(b_eff) + (DATA_W+1)'(b_negate);
    sum          = sum_full[DATA_W-1:0];
    CarryOut     = sum_full[DATA_W];
    // Carry into the MSB recovered from the MSB sum bit and its inputs
    carry_in_msb = sum[DATA_W-1] ^ a_eff[DATA_W-1] ^ b_eff[DATA_W-1];
    Overflow     = carry_in_msb ^ CarryOut;
  end

  // Result mux and zero flag
  always_comb begin
    Result = sum;
    unique case (op_sel)
      2'b00:   Result = a_eff & b_eff;
      2'b01:   Result = a_eff | b_eff;
      2'b10:   Result = sum;
      default: Result = {(DATA_W-1)'(0), sum[DATA_W-1] ^ Overflow};
    endcase
    Zero = (Result == '0);
  end

  // Word index from byte address; upper byte and LSB alias away
  assign mem_idx = Result[MEM_AW:1];

  // Data memory write port; reset clears every word and drops a concurrent write
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite) begin
      mem[mem_idx] <= WriteData;
    end
  end

  // Asynchronous read port, gated by MemRead
  assign ReadData = MemRead ? mem[mem_idx] : '0;

endmodule

// File: tb/tb_alu_16bit.sv
// Directed self-checking bench for alu_16bit.
module tb_alu_16bit;

  logic        Clock;
  logic        Reset;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [1:0]  Opcode;
  logic [15:0] A;
  logic [15:0] B;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] WriteData;
  logic [3:0]  ALUCtrl;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] ReadData;

  int checks = 0;
  int errors = 0;

  alu_16bit dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .Opcode    (Opcode),
    .A         (A),
    .B         (B),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ALUCtrl   (ALUCtrl),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .ReadData  (ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu_set(input logic [1:0] op, input logic [3:0] fn, input logic [1:0] oc,
                         input logic [15:0] a, input logic [15:0] b);
    ALUOp = op; Funct = fn; Opcode = oc; A = a; B = b;
    #1;
  endtask

  initial begin
    Reset = 1'b1; ALUOp = 2'b00; Funct = 4'b0000; Opcode = 2'b00;
    A = 16'h0; B = 16'h0; MemRead = 1'b0; MemWrite = 1'b0; WriteData = 16'h0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    MemRead = 1'b1;
    #1;

    // Post-reset state
    check("rst_ctrl",  16'(ALUCtrl), 16'h0002);
    check("rst_res",   Result,   16'h0000);
    check("rst_zero",  16'(Zero), 16'h0001);
    check("rst_rdata", ReadData, 16'h0000);
    MemRead = 1'b0;

    // Add with signed overflow
    alu_set(2'b10, 4'b0010, 2'b00, 16'h7FFF, 16'h0001);
    check("add_ctrl", 16'(ALUCtrl),  16'h0002);
    check("add_res",  Result,        16'h8000);
    check("add_ov",   16'(Overflow), 16'h0001);
    check("add_co",   16'(CarryOut), 16'h0000);
    check("add_zero", 16'(Zero),     16'h0000);

    // Subtract to zero
    alu_set(2'b01, 4'b0000, 2'b00, 16'h1234, 16'h1234);
    check("sub_ctrl", 16'(ALUCtrl),  16'h0006);
    check("sub_res",  Result,        16'h0000);
    check("sub_zero", 16'(Zero),     16'h0001);
    check("sub_co",   16'(CarryOut), 16'h0001);
    check("sub_ov",   16'(Overflow), 16'h0000);

    // SLT true and false
    alu_set(2'b10, 4'b0100, 2'b00, 16'hFFFE, 16'h0003);
    check("slt_ctrl", 16'(ALUCtrl), 16'h0007);
    check("slt_t",    Result,       16'h0001);
    alu_set(2'b10, 4'b0100, 2'b00, 16'h0003, 16'hFFFE);
    check("slt_f",    Result,       16'h0000);
    check("slt_f_z",  16'(Zero),    16'h0001);

    // NOR, OR, AND and unknown funct
    alu_set(2'b10, 4'b0101, 2'b00, 16'h00F0, 16'h0F00);
    check("nor_ctrl", 16'(ALUCtrl), 16'h000C);
    check("nor_res",  Result,       16'hF00F);
    alu_set(2'b10, 4'b0001, 2'b00, 16'h00F0, 16'h0F00);
    check("or_res",   Result,       16'h0FF0);
    alu_set(2'b10, 4'b0000, 2'b00, 16'h00FF, 16'h0F0F);
    check("and_res",  Result,       16'h000F);
    alu_set(2'b10, 4'b1111, 2'b00, 16'h0001, 16'h0002);
    check("dflt_ctrl", 16'(ALUCtrl), 16'h0002);
    check("dflt_res",  Result,       16'h0003);

    // I-format decode
    alu_set(2'b11, 4'b0000, 2'b10, 16'h00FF, 16'h0F0F);
    check("i_and_ctrl", 16'(ALUCtrl), 16'h0000);
    check("i_and_res",  Result,       16'h000F);
    alu_set(2'b11, 4'b0000, 2'b11, 16'h00FF, 16'h0F0F);
    check("i_or_ctrl",  16'(ALUCtrl), 16'h0001);
    check("i_or_res",   Result,       16'h0FFF);
    alu_set(2'b11, 4'b0000, 2'b00, 16'h0005, 16'h0003);
    check("i_add_res",  Result,       16'h0008);
    alu_set(2'b11, 4'b0000, 2'b01, 16'h0005, 16'h0003);
    check("i_sub_ctrl", 16'(ALUCtrl), 16'h0006);
    check("i_sub_res",  Result,       16'h0002);

    // Memory: write BEEF at 0x0014, read-during-write shows old data first
    @(negedge Clock);
    alu_set(2'b00, 4'b0000, 2'b00, 16'h0014, 16'h0000);
    WriteData = 16'hBEEF; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    check("rdw_old", ReadData, 16'h0000);
    @(posedge Clock); #1;
    check("rdw_new", ReadData, 16'hBEEF);
    @(negedge Clock);
    // Neighbouring word 0x0016 gets different data
    A = 16'h0016; WriteData = 16'h1234;
    @(posedge Clock); #1;
    check("wr_16", ReadData, 16'h1234);
    @(negedge Clock);
    MemWrite = 1'b0;
    A = 16'h0014; #1;
    check("rd_14", ReadData, 16'hBEEF);
    A = 16'h0015; #1;
    check("rd_15_alias", ReadData, 16'hBEEF);
    A = 16'h0114; #1;
    check("rd_114_alias", ReadData, 16'hBEEF);
    MemRead = 1'b0; #1;
    check("rd_disabled", ReadData, 16'h0000);

    // Reset beats a simultaneous write
    @(negedge Clock);
    A = 16'h0014; Reset = 1'b1; MemWrite = 1'b1; WriteData = 16'h1111;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    check("rst_prio_14", ReadData, 16'h0000);
    A = 16'h0016; #1;
    check("rst_clr_16", ReadData, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_16bit.md
ALU_16BIT -- requirements
Module: alu_16bit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows:
- Clock, input, 1 bit: rising-edge clock for all state.
- Reset, input, 1 bit: synchronous, active-high.
- ALUOp, input, 2 bits: operation class from the control unit.
- Funct, input, 4 bits: R-format function field (instruction[3:0]).
- Opcode, input, 2 bits: instruction[15:14], used for I-format decode.
- A, input, 16 bits: operand A.
- B, input, 16 bits: operand B.
- MemRead, input, 1 bit: data memory read enable.
- MemWrite, input, 1 bit: data memory write enable.
- WriteData, input, 16 bits: store data.
- ALUCtrl, output, 4 bits: decoded control; bit 3 = Ainvert, bit 2 = Bnegate, bits [1:0] = operation.
- Result, output, 16 bits: ALU result.
- Zero, output, 1 bit: Result equals 0.
- Overflow, output, 1 bit: signed overflow.
- CarryOut, output, 1 bit: adder carry out of bit 15.
- ReadData, output, 16 bits: data memory read data.

Function
REQ-003 ALUCtrl SHALL decode ALUOp combinationally:
- ALUOp 00 -> 0010 (add).
- ALUOp 01 -> 0110 (sub).
- ALUOp 10 -> decode from Funct.
- ALUOp 11 -> decode from Opcode.
REQ-004 Funct decode (applies when ALUOp is 10):
- 0000 -> 0000 (AND); 0001 -> 0001 (OR); 0010 -> 0010 (ADD).
- 0011 -> 0110 (SUB); 0100 -> 0111 (SLT); 0101 -> 1100 (NOR).
- Any other value -> 0010.
REQ-005 Opcode decode (applies when ALUOp is 11): 00 -> 0010, 01 -> 0110, 10 -> 0000, 11 -> 0001.
REQ-006 The ALU SHALL operate on A' and B', with carry-in = Bnegate:
- A' = Ainvert ? ~A : A.
- B' = Bnegate ? ~B : B.
REQ-007 Operation select (ALUCtrl[1:0]):
- 00 -> A' & B'.
- 01 -> A' | B'.
- 10 -> A' + B' + carry-in, modulo 2^16.
- 11 -> SLT: Result = {15'b0, set}, where set = sum[15] XOR Overflow (signed compare).
REQ-008 Overflow SHALL be (carry into bit 15) XOR (carry out of bit 15), computed from the adder for every operation.
REQ-009 CarryOut SHALL be the adder carry out of bit 15 for every operation.
REQ-010 Zero SHALL be 1 if and only if Result == 16'h0000.
REQ-011 The ALU path SHALL be purely combinational: zero-cycle latency from A, B, ALUOp, Funct and Opcode to all outputs.
REQ-012 Data memory geometry and addressing:
- 128 words x 16 bits, byte-addressed by Result.
- Word index = Result[7:1]; Result[0] and Result[15:8] are ignored, so addresses alias modulo 256.
REQ-013 Write timing: on a rising Clock edge with MemWrite=1 and Reset=0, mem[index] <= WriteData.
REQ-014 Read timing: ReadData = MemRead ? mem[index] : 16'h0000, combinational.
REQ-015 Read-during-write to the same word: ReadData SHALL show the old contents until the edge and the new contents after it.
REQ-016 MemRead=1 and MemWrite=1 together SHALL perform the write and present the read per REQ-014/015.

Reset
REQ-017 While Reset=1 at a rising Clock edge, every memory word SHALL be cleared to 16'h0000.
REQ-018 Reset SHALL take priority over a simultaneous MemWrite, so the write is dropped.
REQ-019 The combinational outputs SHALL NOT depend on Reset; ReadData after reset SHALL be 0.

Structure
REQ-020 A shared package SHALL hold:
- ALUOp encodings.
- The 4-bit ALUCtrl code constants (AND, OR, ADD, SUB, SLT, NOR).
- Memory depth and address-width constants.
REQ-021 The block SHALL contain one sub-module, alu_control, implementing REQ-003 to REQ-005.
REQ-022 The ALU datapath and data memory SHALL be written inline in alu_16bit.

Verification
REQ-023 ADD overflow: ALUOp=10, Funct=0010, A=7FFF, B=0001 -> Result=8000, Overflow=1, CarryOut=0, Zero=0.
REQ-024 SUB to zero: ALUOp=01, A=1234, B=1234 -> ALUCtrl=0110, Result=0000, Zero=1, CarryOut=1, Overflow=0.
REQ-025 SLT and NOR: Funct=0100, A=FFFE (-2), B=0003 -> Result=0001; Funct=0101, A=00F0, B=0F00 -> Result=F00F.
REQ-026 I-format decode: ALUOp=11, Opcode=10, A=00FF, B=0F0F -> ALUCtrl=0000, Result=000F; Opcode=11 -> Result=0FFF.
REQ-027 Memory write/read with aliasing:
- Write WriteData=BEEF at address 0x0014, MemWrite=1, one edge.
- Read back at address 0x0015 with MemRead=1 -> ReadData=BEEF.
- Read back at address 0x0114 -> ReadData=BEEF.
- MemRead=0 -> ReadData=0000.
REQ-028 Reset priority: after REQ-027, assert Reset with MemWrite=1 and WriteData=1111 for one edge -> reading 0x0014 returns 0000.
